// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction ROM port, decode-side valid/ready handshake,
// redirect input and halt/fault status. The master modport is the fetch unit;
// the slave modport is the environment (ROM, consumer, branch resolution).
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        fault;

   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid, halted, fault,
      input  imem_rdata, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted, fault,
      output imem_rdata, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues reads to a synchronous ROM (1-cycle
// latency), buffers {word, pc} in a prefetch FIFO and presents the head over a
// valid/ready handshake. Stops after delivering EBREAK; a redirect flushes and
// restarts fetch at a new PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect target
// parks the unit in a FAULT state instead of being silently aligned.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   instr_fetch_unit_if.master bus
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam int          PTR_W  = $clog2(FIFO_DEPTH);
   localparam int          CNT_W  = PTR_W + 1;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HALTED
`ifdef FETCH_MISALIGN_TRAP_EN
      , S_FAULT
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q;
   logic               inflight_q;
   logic [31:0]        inflight_pc_q;
   logic [CNT_W-1:0]   count_q;
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [31:0]        fifo_data [FIFO_DEPTH];
   logic [31:0]        fifo_pc   [FIFO_DEPTH];

   logic               redirect;
   logic [31:0]        redirect_target;
   logic               resp_ebreak;
   logic               push;
   logic               pop;
   logic               head_valid;
   logic               issue;

   assign redirect        = bus.redirect_valid;
   // Low address bits are dropped so the fetch PC is always word aligned.
   assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
   assign resp_ebreak     = inflight_q && (bus.imem_rdata == EBREAK);

   // Responses are only kept while running and not being flushed.
   assign push       = inflight_q && (state_q == S_RUN) && !redirect;
   assign head_valid = (count_q != '0) && ((state_q == S_RUN) || (state_q == S_DRAIN));
   assign pop        = head_valid && bus.instr_ready;

   // Credit check counts the in-flight word so a response always finds a free slot;
   // an arriving EBREAK stops issue in the same cycle.
   assign issue = reset_n && (state_q == S_RUN) && !redirect && !resp_ebreak &&
                  ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));

   assign bus.imem_req    = issue;
   assign bus.imem_addr   = issue ? fetch_pc_q : 32'h0;
   assign bus.instr_valid = head_valid;
   assign bus.instr       = head_valid ? fifo_data[rd_ptr_q] : 32'h0;
   assign bus.instr_pc    = head_valid ? fifo_pc[rd_ptr_q]   : 32'h0;
   assign bus.halted      = (state_q == S_HALTED);
`ifdef FETCH_MISALIGN_TRAP_EN
   assign bus.fault       = (state_q == S_FAULT);
`else
   assign bus.fault       = 1'b0;
`endif

   // Next-state logic: redirect overrides everything, then EBREAK drain/halt.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      if (redirect) begin
         state_d = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
         end
`endif
      end else begin
         case (state_q)
            S_RUN:   if (push && resp_ebreak)            state_d = S_DRAIN;
            S_DRAIN: if (pop && (count_q == CNT_W'(1))) state_d = S_HALTED;
            default: state_d = state_q;
         endcase
      end
   end

   // Control state: FSM, PC, in-flight tracking and FIFO pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_RUN;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q    <= state_d;
         inflight_q <= issue;
         if (issue) begin
            inflight_pc_q <= fetch_pc_q;
         end
         if (redirect) begin
            fetch_pc_q <= redirect_target;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
         end else begin
            if (issue) fetch_pc_q <= fetch_pc_q + 32'd4;
            if (push)  wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Prefetch storage: written on push, read at the head pointer.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; count_q gates every read, so stale contents are never visible.
      if (push) begin
         fifo_data[wr_ptr_q] <= bus.imem_rdata;
         fifo_pc[wr_ptr_q]   <= inflight_pc_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: reset, straight-line fetch to
// EBREAK, back-pressure, redirect flush, redirect from halt, PC wrap, misaligned
// redirect (both builds of FETCH_MISALIGN_TRAP_EN) and mid-run reset.
module tb_instr_fetch_unit;

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ADDI0  = 32'h00A0_0093;  // addi x1,x0,10
   localparam logic [31:0] ADDI1  = 32'h0280_8093;  // addi x1,x1,40

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] ebreak_addr;
   int          total = 0;
   int          bad   = 0;
   int          req_count = 0;
   int          req_snap;
   logic [31:0] delivered [$];
   logic [31:0] entry;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   // ROM contents: small program at 0, EBREAK at a movable address, filler elsewhere.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == ebreak_addr) return EBREAK;
      case (a)
         32'h0:   return ADDI0;
         32'h4:   return ADDI1;
         default: return 32'hA000_0000 | a;
      endcase
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge clk) bus.imem_rdata <= rom_word(bus.imem_addr);

   // Monitors: request count and log of accepted instruction PCs.
   always @(posedge clk) begin
      if (bus.imem_req) req_count <= req_count + 1;
      if (bus.instr_valid && bus.instr_ready) delivered.push_back(bus.instr_pc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n            = 1'b0;
      ebreak_addr        = 32'h8;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      tick(2);
      #1;
      check("rst_req",    bus.imem_req,    0);
      check("rst_addr",   bus.imem_addr,   0);
      check("rst_valid",  bus.instr_valid, 0);
      check("rst_instr",  bus.instr,       0);
      check("rst_pc",     bus.instr_pc,    0);
      check("rst_halted", bus.halted,      0);
      check("rst_fault",  bus.fault,       0);

      // Straight-line program ending in EBREAK.
      reset_n = 1'b1;
      #1;
      check("p_req0",  bus.imem_req,  1);
      check("p_addr0", bus.imem_addr, 32'h0);
      tick(1); #1;
      check("p_addr4",  bus.imem_addr,   32'h4);
      check("p_valid0", bus.instr_valid, 0);
      tick(1); #1;
      check("p_v_pc0",  bus.instr_valid, 1);
      check("p_pc0",    bus.instr_pc,    32'h0);
      check("p_in0",    bus.instr,       ADDI0);
      tick(1); #1;
      check("p_pc4",    bus.instr_pc,    32'h4);
      check("p_in4",    bus.instr,       ADDI1);
      tick(1); #1;
      check("p_pc8",    bus.instr_pc,    32'h8);
      check("p_in8",    bus.instr,       EBREAK);
      check("p_nohalt", bus.halted,      0);
      tick(1); #1;
      check("h_halted", bus.halted,      1);
      check("h_req",    bus.imem_req,    0);
      check("h_valid",  bus.instr_valid, 0);

      // Redirect out of HALTED to 0 with the consumer stalled.
      tick(1);
      ebreak_addr        = 32'h1000;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      #1;
      check("hr_req_kill", bus.imem_req, 0);
      tick(1);
      bus.redirect_valid = 1'b0;
      #1;
      check("hr_halted", bus.halted,    0);
      check("hr_req",    bus.imem_req,  1);
      check("hr_addr",   bus.imem_addr, 32'h0);
      req_snap = req_count;
      delivered.delete();

      // Back-pressure: exactly FIFO_DEPTH requests, head stays put.
      tick(2); #1;
      check("s_valid", bus.instr_valid, 1);
      check("s_pc",    bus.instr_pc,    32'h0);
      tick(3); #1;
      check("s_in_hold", bus.instr,     ADDI0);
      check("s_pc_hold", bus.instr_pc,  32'h0);
      tick(5); #1;
      check("s_reqs",    req_count - req_snap, 4);
      check("s_req_off", bus.imem_req,  0);
      check("s_in_end",  bus.instr,     ADDI0);

      // Pop two entries, then stall again so the FIFO holds 0x8..0x14.
      bus.instr_ready = 1'b1;
      tick(1); #1;
      check("r_pc4", bus.instr_pc, 32'h4);
      tick(1);
      bus.instr_ready = 1'b0;
      #1;
      check("r_pc8", bus.instr_pc, 32'h8);
      tick(4); #1;
      check("f_pc8",   bus.instr_pc,    32'h8);
      check("f_full",  bus.imem_req,    0);

      // Redirect to 0x40 flushes 0x8..0x14.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      #1;
      check("rd_req_kill", bus.imem_req, 0);
      tick(1);
      bus.redirect_valid = 1'b0;
      bus.instr_ready    = 1'b1;
      #1;
      check("rd_valid0", bus.instr_valid, 0);
      check("rd_addr",   bus.imem_addr,   32'h40);
      tick(2); #1;
      check("rd_pc40",   bus.instr_pc,    32'h40);
      tick(1); #1;
      check("rd_pc44",   bus.instr_pc,    32'h44);
      check("rd_logsz",  delivered.size(), 3);
      entry = (delivered.size() > 2) ? delivered[2] : 32'hDEAD_BEEF;
      check("rd_log2",   entry, 32'h40);

      // Redirect near the top of the address space: PC wraps to 0.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFF8;
      tick(1);
      bus.redirect_valid = 1'b0;
      #1;
      check("w_addr0", bus.imem_addr,   32'hFFFF_FFF8);
      check("w_valid", bus.instr_valid, 0);
      tick(1); #1;
      check("w_addr1", bus.imem_addr,   32'hFFFF_FFFC);
      tick(1); #1;
      check("w_addr2", bus.imem_addr,   32'h0);
      check("w_pc0",   bus.instr_pc,    32'hFFFF_FFF8);
      tick(1); #1;
      check("w_pc1",   bus.instr_pc,    32'hFFFF_FFFC);
      tick(1); #1;
      check("w_pc2",   bus.instr_pc,    32'h0);
      check("w_in2",   bus.instr,       ADDI0);

      // Misaligned redirect target.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h42;
      tick(1);
      bus.redirect_valid = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("m_fault", bus.fault,    1);
      check("m_req",   bus.imem_req, 0);
      tick(1); #1;
      check("m_fault_hold", bus.fault,       1);
      check("m_req_hold",   bus.imem_req,    0);
      tick(1); #1;
      check("m_valid",      bus.instr_valid, 0);
`else
      check("m_fault", bus.fault,     0);
      check("m_addr",  bus.imem_addr, 32'h40);
      tick(2); #1;
      check("m_valid", bus.instr_valid, 1);
      check("m_pc",    bus.instr_pc,    32'h40);
      check("m_in",    bus.instr,       32'hA000_0040);
`endif

      // Aligned redirect recovers (leaves FAULT when the trap is enabled).
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h44;
      tick(1);
      bus.redirect_valid = 1'b0;
      #1;
      check("a_fault", bus.fault,     0);
      check("a_addr",  bus.imem_addr, 32'h44);
      tick(2); #1;
      check("a_pc",    bus.instr_pc,  32'h44);
      check("a_in",    bus.instr,     32'hA000_0044);

      // Asynchronous reset in the middle of streaming.
      tick(1);
      reset_n = 1'b0;
      #1;
      check("mr_valid", bus.instr_valid, 0);
      check("mr_req",   bus.imem_req,    0);
      check("mr_instr", bus.instr,       0);
      check("mr_pc",    bus.instr_pc,    0);
      tick(1);
      reset_n = 1'b1;
      #1;
      check("mr_addr0", bus.imem_addr,   32'h0);
      tick(2); #1;
      check("mr_pc0",   bus.instr_pc,    32'h0);
      check("mr_in0",   bus.instr,       ADDI0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
